// File: rtl/mult_issue_ctrl.sv
// Issue stage for the iterative signed 32x32 multiplier: operand FIFO, one-at-a-time issue, result register.
// Optional MULT_ZERO_BYPASS_EN: zero-operand pairs complete in IDLE without starting the multiplier.
module mult_issue_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PTR_W      = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_op1,
   input  logic [31:0]      in_op2,
   output logic             mult_begin,
   output logic [31:0]      mult_op1,
   output logic [31:0]      mult_op2,
   input  logic [63:0]      mult_product,
   input  logic             mult_overflow,
   input  logic             mult_end,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_hi,
   output logic [31:0]      out_lo,
   output logic             out_overflow,
   output logic             busy,
   output logic [PTR_W:0]   fifo_count
);
   localparam int unsigned OP_W  = 32;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [2*OP_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [OP_W-1:0]     head_op1;
   logic [OP_W-1:0]     head_op2;
   logic                full;
   logic                empty;
   logic                push;
   logic                slot_free;
   logic                issue;
   logic                head_zero;
   logic                bypass;

   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign empty      = (count == '0);
   assign in_ready   = !full;
   assign push       = in_valid && !full;
   assign {head_op1, head_op2} = mem[rd_ptr];
   assign slot_free  = !out_valid || out_ready;
   assign issue      = (state == IDLE) && !empty && slot_free;
   assign busy       = (state == RUN) || !empty;
   assign fifo_count = count;

`ifdef MULT_ZERO_BYPASS_EN
   assign head_zero = (head_op1 == '0) || (head_op2 == '0);
`else
   assign head_zero = 1'b0;
`endif
   assign bypass = issue && head_zero;

   // Operand storage; occupancy is tracked by count, so entries need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_op1, in_op2};
      end
   end

   // Pointers, issue FSM and result register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         mult_begin   <= 1'b0;
         mult_op1     <= '0;
         mult_op2     <= '0;
         out_valid    <= 1'b0;
         out_hi       <= '0;
         out_lo       <= '0;
         out_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (issue) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !issue) begin
            count <= count + CNT_W'(1);
         end else if (!push && issue) begin
            count <= count - CNT_W'(1);
         end

         // A capture later in this block overrides the consume.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               mult_begin <= 1'b0;
               if (bypass) begin
                  out_hi       <= '0;
                  out_lo       <= '0;
                  out_overflow <= 1'b0;
                  out_valid    <= 1'b1;
               end else if (issue) begin
                  mult_op1   <= head_op1;
                  mult_op2   <= head_op2;
                  mult_begin <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (mult_end) begin
                  out_hi       <= mult_product[2*OP_W-1:OP_W];
                  out_lo       <= mult_product[OP_W-1:0];
                  out_overflow <= mult_overflow;
                  out_valid    <= 1'b1;
                  mult_begin   <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: behavioural multiplier, in-order result scoreboard, directed and random traffic.
module tb_mult_issue_ctrl;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 2;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_op1 = '0;
   logic [31:0]   in_op2 = '0;
   logic          mult_begin;
   logic [31:0]   mult_op1;
   logic [31:0]   mult_op2;
   logic [63:0]   mult_product;
   logic          mult_overflow;
   logic          mult_end;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_hi;
   logic [31:0]   out_lo;
   logic          out_overflow;
   logic          busy;
   logic [PW:0]   fifo_count;

   mult_issue_ctrl #(.FIFO_DEPTH(DEPTH), .PTR_W(PW)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_op2(in_op2),
      .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
      .mult_product(mult_product), .mult_overflow(mult_overflow), .mult_end(mult_end),
      .out_valid(out_valid), .out_ready(out_ready), .out_hi(out_hi), .out_lo(out_lo),
      .out_overflow(out_overflow), .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
   typedef struct { logic [63:0] p; logic ov; } res_t;

   function automatic res_t mult_ref(input logic [31:0] a, input logic [31:0] b);
      res_t   r;
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint p  = sa * sb;
      r.p  = 64'(p);
      r.ov = (p != longint'(int'(p)));
      return r;
   endfunction

   function automatic int lat_of(input logic [31:0] b);
      logic [31:0] m = b[31] ? -b : b;
      int n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i;
      return n;
   endfunction

   // Behavioural iterative multiplier: latency grows with |op2|, junk on the product bus when not ending.
   logic        m_run = 1'b0;
   int          m_cnt = 0;
   res_t        m_res;
   logic [63:0] junk = '0;
   assign mult_end      = m_run && (m_cnt == 0);
   assign mult_product  = mult_end ? m_res.p  : junk;
   assign mult_overflow = mult_end ? m_res.ov : junk[0];

   always @(posedge clk) begin
      junk <= {$urandom, $urandom};
      if (!mult_begin) m_run <= 1'b0;
      else if (!m_run) begin
         m_run <= 1'b1;
         m_cnt <= lat_of(mult_op2);
         m_res <= mult_ref(mult_op1, mult_op2);
      end else if (m_cnt == 0) m_run <= 1'b0;
      else m_cnt <= m_cnt - 1;
   end

   // Reference model: queue of pairs awaiting issue, queue of results awaiting delivery.
   pair_t       pend[$];
   res_t        expq[$];
   pair_t       h;
   res_t        e;
   logic        prev_begin = 0, prev_end = 0, prev_hold = 0, pushed_prev = 0, rise;
   logic [31:0] prev_op1, prev_op2, prev_hi, prev_lo;
   logic        prev_ov, prev_pov;
   logic [63:0] prev_prod;
   int          model_cnt = 0;

   always @(negedge clk) begin
      if (!resetn) begin
         pend.delete();
         expq.delete();
         prev_begin = 0; prev_end = 0; prev_hold = 0; pushed_prev = 0;
         model_cnt = 0;
      end else begin
         rise = mult_begin && !prev_begin;
         if (prev_end) begin
            check("begin_drop_after_end", mult_begin, 0);
            check("capture_valid", out_valid, 1);
            check("capture_data", {out_hi, out_lo}, prev_prod);
            check("capture_ovf", out_overflow, prev_pov);
         end
         if (mult_begin && prev_begin) begin
            check("op1_hold", mult_op1, prev_op1);
            check("op2_hold", mult_op2, prev_op2);
         end
         if (rise) begin
`ifdef MULT_ZERO_BYPASS_EN
            while (pend.size() > 0 && (pend[0].a == 0 || pend[0].b == 0)) void'(pend.pop_front());
`endif
            if (pend.size() == 0) check("issue_without_entry", 1, 0);
            else begin
               h = pend.pop_front();
               check("issue_op1", mult_op1, h.a);
               check("issue_op2", mult_op2, h.b);
            end
         end
         if (prev_hold && !prev_end) begin
            check("park_valid", out_valid, 1);
            check("park_data", {out_hi, out_lo}, {prev_hi, prev_lo});
            check("park_ovf", out_overflow, prev_ov);
         end
`ifndef MULT_ZERO_BYPASS_EN
         model_cnt = model_cnt + (pushed_prev ? 1 : 0) - (rise ? 1 : 0);
         check("fifo_count", 64'(fifo_count), 64'(model_cnt));
         check("in_ready", in_ready, model_cnt != DEPTH);
`endif
         if (out_valid && out_ready) begin
            if (expq.size() == 0) check("result_unexpected", 1, 0);
            else begin
               e = expq.pop_front();
               check("result_data", {out_hi, out_lo}, e.p);
               check("result_ovf", out_overflow, e.ov);
            end
         end
         pushed_prev = in_valid && in_ready;
         if (pushed_prev) begin
            pend.push_back('{a: in_op1, b: in_op2});
            expq.push_back(mult_ref(in_op1, in_op2));
         end
         prev_begin = mult_begin;
         prev_end   = mult_end;
         prev_prod  = mult_product;
         prev_pov   = mult_overflow;
         prev_hold  = out_valid && !out_ready;
         prev_op1 = mult_op1; prev_op2 = mult_op2;
         prev_hi = out_hi; prev_lo = out_lo; prev_ov = out_overflow;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Offer a pair until accepted; returns 1 ns after the accepting edge.
   task automatic push(input logic [31:0] a, input logic [31:0] b);
      in_op1 = a; in_op2 = b; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
      end
      check("push_timeout", 1, 0);
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) return;
      end
      check("out_valid_timeout", 1, 0);
   endtask

   task automatic wait_begin();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mult_begin) return;
      end
      check("mult_begin_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      out_ready = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!busy && !out_valid) return;
      end
      check("drain_timeout", 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      resetn = 1'b1;
      @(negedge clk);
      check("rst_begin", mult_begin, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", {out_hi, out_lo, 31'd0, out_overflow}, 0);
      check("rst_ops", {mult_op1, mult_op2}, 0);
      check("rst_count", fifo_count, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);

      // Single operation.
      out_ready = 1'b1;
      tick();
      push(32'd3, 32'd5);
      wait_begin();
      wait_out();
      check("p1_hi", out_hi, 32'h0);
      check("p1_lo", out_lo, 32'hF);
      check("p1_ovf", out_overflow, 0);
      check("p1_begin_low", mult_begin, 0);

      // Back-to-back pair with sign and overflow.
      tick();
      push(-32'sd7, 32'd6);
      push(32'h7FFF_FFFF, 32'd2);
      wait_out();
      check("p2_hi", out_hi, 32'hFFFF_FFFF);
      check("p2_lo", out_lo, 32'hFFFF_FFD6);
      check("p2_ovf", out_overflow, 0);
      wait_out();
      check("p3_hi", out_hi, 32'h0);
      check("p3_lo", out_lo, 32'hFFFF_FFFE);
      check("p3_ovf", out_overflow, 1);
      wait_idle();

      // Parked result backs the FIFO up to full.
      out_ready = 1'b0;
      tick();
      push(32'h11, 32'h3);
      wait_out();
      tick();
      for (int i = 0; i < 4; i++) push(32'(i + 20), 32'(i + 1));
      @(negedge clk);
      check("full_count", fifo_count, DEPTH);
      check("full_in_ready", in_ready, 0);
      tick();
      in_op1 = 32'h99; in_op2 = 32'h2; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("full_refuse", in_ready, 0);
         check("full_no_issue", mult_begin, 0);
         check("full_park_lo", out_lo, 32'h33);
         tick();
      end
      in_valid = 1'b0;
      wait_idle();

      // Reset during RUN with two entries queued.
      tick();
      push(32'd5, 32'h4000_0000);
      push(32'd6, 32'd7);
      push(32'd8, 32'd9);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mult_begin && fifo_count == 2) break;
      end
      check("pre_rst_run", {mult_begin, fifo_count}, {1'b1, 3'd2});
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      @(negedge clk);
      check("mid_rst_begin", mult_begin, 0);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      tick();
      push(32'd2, 32'd2);
      wait_out();
      check("post_rst_lo", out_lo, 32'd4);
      check("post_rst_hi", out_hi, 32'd0);
      wait_idle();

      // Zero operand.
      tick();
      push(32'd0, 32'h1234_5678);
`ifdef MULT_ZERO_BYPASS_EN
      @(negedge clk);
      check("zb_not_yet", {out_valid, mult_begin}, 0);
      @(negedge clk);
      check("zb_valid", out_valid, 1);
      check("zb_data", {out_hi, out_lo, out_overflow}, 0);
      check("zb_no_begin", mult_begin, 0);
`else
      wait_begin();
      check("zero_begin", mult_begin, 1);
      wait_out();
      check("zero_data", {out_hi, out_lo, out_overflow}, 0);
`endif
      wait_idle();

      // Simultaneous push and pop at occupancy 2.
      out_ready = 1'b0;
      tick();
      push(32'd1, 32'd1);
      wait_out();
      tick();
      push(32'd2, 32'd3);
      push(32'd4, 32'd5);
      @(negedge clk);
      check("pp_pre_count", fifo_count, 2);
      tick();
      in_op1 = 32'd6; in_op2 = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("pp_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("pp_count", fifo_count, 2);
      check("pp_issue", mult_begin, 1);
      wait_idle();

      // Random traffic.
      tick();
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_op1    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         in_op2    = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) in_op2 = -in_op2;
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      in_valid = 1'b0;
      wait_idle();
      @(negedge clk);
      check("scoreboard_empty", 64'(expq.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
